// File: rtl/key_beep_ctrl.sv
// Short/long key-press classifier with beeper enable, 4-tone select and square-wave buzzer drive.
// Optional macro BEEP_AUTO_OFF_EN adds an auto-off timeout of OFF_CNT cycles while enabled.
module key_beep_ctrl #(
  parameter int LONG_CNT = 50000000,
  parameter int HALF0    = 95556,
  parameter int HALF1    = 85131,
  parameter int HALF2    = 75843,
  parameter int HALF3    = 71586,
  parameter int OFF_CNT  = 500000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  output logic       beep,
  output logic       beep_en,
  output logic [1:0] tone_sel,
  output logic       short_pulse,
  output logic       long_pulse
);

  localparam int HALF_A   = (HALF0 > HALF1) ? HALF0 : HALF1;
  localparam int HALF_B   = (HALF2 > HALF3) ? HALF2 : HALF3;
  localparam int HALF_MAX = (HALF_A > HALF_B) ? HALF_A : HALF_B;
  localparam int HW       = $clog2(LONG_CNT);
  localparam int DW       = $clog2(HALF_MAX);

  typedef enum logic [1:0] {IDLE, PRESS, HOLD} state_t;

  state_t        state;
  logic          key_r;
  logic [HW-1:0] hold_cnt;
  logic [DW-1:0] div_cnt;
  logic [DW-1:0] half_m1;
  logic          press;
  logic          rel;
  logic          long_hit;
  logic          short_hit;

  assign press     = key_r & ~key_in;
  assign rel       = ~key_r & key_in;
  // A release on the very edge the hold count matures still classifies as long.
  assign long_hit  = (state == PRESS) && (hold_cnt == HW'(LONG_CNT - 1));
  assign short_hit = (state == PRESS) && rel && !long_hit;

  always_comb begin
    half_m1 = DW'(HALF0 - 1);
    case (tone_sel)
      2'd0: half_m1 = DW'(HALF0 - 1);
      2'd1: half_m1 = DW'(HALF1 - 1);
      2'd2: half_m1 = DW'(HALF2 - 1);
      2'd3: half_m1 = DW'(HALF3 - 1);
      default: half_m1 = DW'(HALF0 - 1);
    endcase
  end

`ifdef BEEP_AUTO_OFF_EN
  localparam int OW = $clog2(OFF_CNT);
  logic [OW-1:0] off_cnt;
  logic          off_hit;

  // A long-press strobe restarts the timeout rather than expiring it.
  assign off_hit = beep_en && !long_hit && (off_cnt == OW'(OFF_CNT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_cnt <= '0;
    end else if (!beep_en || short_hit || long_hit || off_hit) begin
      off_cnt <= '0;
    end else begin
      off_cnt <= off_cnt + OW'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_r       <= 1'b1;
      state       <= IDLE;
      hold_cnt    <= '0;
      div_cnt     <= '0;
      beep        <= 1'b0;
      beep_en     <= 1'b0;
      tone_sel    <= 2'd0;
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
    end else begin
      key_r       <= key_in;
      short_pulse <= short_hit;
      long_pulse  <= long_hit;

      case (state)
        IDLE: begin
          if (press) begin
            state    <= PRESS;
            hold_cnt <= '0;
          end
        end
        PRESS: begin
          if (long_hit) begin
            state    <= key_in ? IDLE : HOLD;
            tone_sel <= tone_sel + 2'd1;
          end else if (rel) begin
            state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        HOLD: begin
          if (rel) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (short_hit) begin
        beep_en <= ~beep_en;
`ifdef BEEP_AUTO_OFF_EN
      end else if (off_hit) begin
        beep_en <= 1'b0;
`endif
      end

      // Restart the divider on a tone change so the held level lasts a full new half-period.
      if (!beep_en) begin
        div_cnt <= '0;
        beep    <= 1'b0;
      end else if (long_hit) begin
        div_cnt <= '0;
      end else if (div_cnt == half_m1) begin
        div_cnt <= '0;
        beep    <= ~beep;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

endmodule

// File: tb/tb_key_beep_ctrl.sv
// Bench for key_beep_ctrl: press-length table, reset-mid-press sequence, random presses vs a time-based model.
module tb_key_beep_ctrl;

  localparam int LONG = 100;
  localparam int H0 = 4, H1 = 6, H2 = 8, H3 = 10;
  localparam int OFF = 500;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_in;
  logic       beep, beep_en, short_pulse, long_pulse;
  logic [1:0] tone_sel;

  always #5 clk = ~clk;

  key_beep_ctrl #(
    .LONG_CNT(LONG), .HALF0(H0), .HALF1(H1), .HALF2(H2), .HALF3(H3), .OFF_CNT(OFF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .beep(beep), .beep_en(beep_en),
    .tone_sel(tone_sel), .short_pulse(short_pulse), .long_pulse(long_pulse)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic int half_of(input logic [1:0] t);
    case (t)
      2'd0: return H0;
      2'd1: return H1;
      2'd2: return H2;
      default: return H3;
    endcase
  endfunction

  // Reference model: press length measured in cycles since detection, beep level derived
  // arithmetically from the time elapsed since the last enable or tone change.
  bit         m_key_prev, m_pressing, m_long_done, m_en, m_beep, m_short, m_long, ref_lvl;
  logic [1:0] m_tone;
  int         cyc, press_cyc, ref_cyc, off_ref;
  bit         pr, rl, tchg, en_before;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_key_prev = 1; m_pressing = 0; m_long_done = 0; m_en = 0; m_beep = 0;
      m_short = 0; m_long = 0; m_tone = 0; cyc = 0; press_cyc = 0;
      ref_cyc = 0; ref_lvl = 0; off_ref = 0;
    end else begin
      cyc++;
      pr = m_key_prev && !key_in;
      rl = !m_key_prev && key_in;
      m_key_prev = key_in;
      m_short = 0; m_long = 0; tchg = 0;
      en_before = m_en;
      if (m_pressing) begin
        if (!m_long_done && (cyc - press_cyc) == LONG) begin
          m_long = 1; m_tone = m_tone + 2'd1; tchg = 1; m_long_done = 1;
          if (key_in) m_pressing = 0;
        end else if (rl) begin
          if (!m_long_done) begin m_short = 1; m_en = !m_en; end
          m_pressing = 0;
        end
      end else if (pr) begin
        m_pressing = 1; press_cyc = cyc; m_long_done = 0;
      end
`ifdef BEEP_AUTO_OFF_EN
      if (m_short || m_long || !en_before) off_ref = cyc;
      else if ((cyc - off_ref) == OFF) begin m_en = 0; off_ref = cyc; end
`endif
      if (!en_before) begin
        m_beep = 0; ref_cyc = cyc; ref_lvl = 0;
      end else if (tchg) begin
        ref_cyc = cyc; ref_lvl = m_beep;
      end else begin
        m_beep = ref_lvl ^ ((((cyc - ref_cyc) / half_of(m_tone)) % 2) == 1);
      end
    end
  end

  bit chk_on = 0;
  int n_short = 0, n_long = 0;

  always @(negedge clk) begin
    if (short_pulse === 1'b1) n_short++;
    if (long_pulse === 1'b1) n_long++;
    if (chk_on)
      check("cycle_model", {26'd0, beep, beep_en, tone_sel, short_pulse, long_pulse},
            {26'd0, m_beep, m_en, m_tone, m_short, m_long});
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_for(input int n);
    key_in = 1'b0;
    step(n);
    key_in = 1'b1;
  endtask

  task automatic measure_half(output int h);
    logic b;
    int   t;
    h = -1;
    b = beep; t = 0;
    while (beep == b && t < 40) begin step(1); t++; end
    if (t >= 40) return;
    b = beep; t = 0;
    while (beep == b && t < 40) begin step(1); t++; end
    if (t < 40) h = t;
  endtask

  typedef struct {
    int         len;
    int         es;
    int         el;
    logic       en;
    logic [1:0] tone;
    int         half;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, l0, h, len, r;

    vecs[0] = '{20,  1, 0, 1'b1, 2'd0, H0};
    vecs[1] = '{300, 0, 1, 1'b1, 2'd1, H1};
    vecs[2] = '{100, 0, 1, 1'b1, 2'd2, H2};
    vecs[3] = '{99,  1, 0, 1'b0, 2'd2, 0};
    vecs[4] = '{101, 0, 1, 1'b0, 2'd3, 0};
    vecs[5] = '{150, 0, 1, 1'b0, 2'd0, 0};
    vecs[6] = '{1,   1, 0, 1'b1, 2'd0, H0};
    vecs[7] = '{250, 0, 1, 1'b1, 2'd1, H1};
    vecs[8] = '{100, 0, 1, 1'b1, 2'd2, H2};
    vecs[9] = '{200, 0, 1, 1'b1, 2'd3, H3};

    rst_n = 1'b0; key_in = 1'b1;
    @(posedge clk); #1;
    chk_on = 1;
    step(3);
    rst_n = 1'b1;
    step(50);
    check("idle_outputs", {beep, beep_en, tone_sel, short_pulse, long_pulse}, 6'd0);
    check("idle_no_strobes", n_short + n_long, 0);

    for (int i = 0; i < 10; i++) begin
      s0 = n_short; l0 = n_long;
      press_for(vecs[i].len);
      step(20);
      check($sformatf("vec%0d_short_cnt", i), n_short - s0, vecs[i].es);
      check($sformatf("vec%0d_long_cnt", i), n_long - l0, vecs[i].el);
      check($sformatf("vec%0d_beep_en", i), beep_en, vecs[i].en);
      check($sformatf("vec%0d_tone", i), tone_sel, vecs[i].tone);
      if (vecs[i].en) begin
        measure_half(h);
        check($sformatf("vec%0d_half", i), h, vecs[i].half);
      end
    end

    // Reset while the key is held and the beeper is running.
    key_in = 1'b0;
    step(30);
    rst_n = 1'b0;
    step(1);
    check("rst_outputs", {beep, beep_en, tone_sel, short_pulse, long_pulse}, 6'd0);
    step(1);
    key_in = 1'b1;
    step(1);
    rst_n = 1'b1;
    s0 = n_short; l0 = n_long;
    step(30);
    check("post_rst_no_strobe", (n_short - s0) + (n_long - l0), 0);
    check("post_rst_state", {beep_en, tone_sel}, 3'd0);
    press_for(10);
    step(5);
    check("post_rst_press_short", n_short - s0, 1);
    check("post_rst_press_en", beep_en, 1'b1);

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) len = LONG - 1;
      else if (r == 1) len = LONG;
      else if (r == 2) len = LONG + 1;
      else if (r < 7) len = $urandom_range(1, LONG - 2);
      else len = $urandom_range(LONG + 2, 220);
      press_for(len);
      step($urandom_range(1, 30));
    end

`ifdef BEEP_AUTO_OFF_EN
    if (beep_en) begin press_for(5); step(5); end
    press_for(5);
    step(1);
    h = 0;
    while (beep_en && h < 600) begin step(1); h++; end
    check("auto_off_cycles", h, OFF);
    step(1);
    check("auto_off_beep", beep, 1'b0);
`endif

    step(10);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
